instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Encoder side of the 16-bit instruction format consumed by the core's instruction decoder.
- Accepts field-level instruction requests (opcode plus a/b/c register nibbles) over valid/ready and packs them into canonical 16-bit words.
- Buffers the packed words in a small FIFO and streams them, each tagged with a sequential address, to the instruction-memory write port.
- Stops accepting input once a Halt is encoded, and reports reserved opcodes.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 8, width of instruction-memory write address

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request carries a valid instruction
in_ready  output  1  encoder can accept this cycle
in_op  input  4  opcode (0 Noop, 1 ALU, 2 AddImm, 3 XorImm, 4 Mov, 5 Shift, 6 Mult, 7 Hash, 8 ReadRAM, 9 WriteRAM, 10 Jump, 11 WriteImm, 12 Cjump, 13/14 reserved, 15 Halt)
in_a  input  4  field a
in_b  input  4  field b
in_c  input  4  field c
out_valid  output  1  out_instr/out_addr valid
out_ready  input  1  memory port accepts word
out_instr  output  16  packed word
out_addr  output  ADDR_W  write address of out_instr
restart  input  1  leave HALTED, clear status, address back to 0
halted  output  1  in HALTED state
err_reserved  output  1  sticky: reserved opcode received
level  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=RUN, FIFO empty, in_ready=1 after reset release;
  - out_valid=0, out_instr=0, out_addr=0, halted=0, err_reserved=0, level=0.
- Packing: word = {in_a, in_b, in_c, in_op}, i.e. a=[15:12], b=[11:8], c=[7:4], op=[3:0].
  - Canonicalisation: op 0 encodes as 16'h0000 and op 15 encodes as 16'h000F; fields are ignored for both.
- Input handshake: transfer when in_valid && in_ready.
  - in_ready = (state==RUN) && (level<DEPTH); it is purely combinational on registered state and never depends on in_valid.
  - A pop in the same cycle does not free space for a push while full: in_ready stays 0 when level==DEPTH.
- Reserved op 13/14:
  - The handshake completes, but nothing is pushed.
  - err_reserved is set the next cycle and holds until restart or reset.
- Output: FIFO head is driven from registers.
  - Latency from input transfer into an empty FIFO to out_valid=1 is one cycle.
  - Output transfer happens when out_valid && out_ready.
  - On transfer, out_addr increments by 1 modulo 2^ADDR_W (wraps from all-ones to 0).
  - out_instr/out_addr are stable while out_valid && !out_ready.
- Simultaneous push and pop: level unchanged, ordering preserved (FIFO, no reordering).
- States:
  - RUN: accepts input. Accepting op 15 pushes the Halt word and moves to DRAIN.
  - DRAIN: in_ready=0. When the FIFO becomes empty (last word, the Halt, transferred), move to HALTED.
  - HALTED: halted=1, in_ready=0, out_valid=0. restart=1 for one cycle returns to RUN, sets out_addr=0 and clears err_reserved. halted drops the cycle after restart.
  - restart is ignored in RUN and DRAIN.
- level reports current occupancy (0..DEPTH), updated on the clock edge.
- rst_n asserted mid-stream discards FIFO contents immediately; no partial word is ever emitted.

Test Plan:
- Reset, then push op=1 a=3 b=5 c=7 -> next cycle out_valid=1, out_instr=16'h3571, out_addr=0; after the out transfer, out_addr=1.
- Hold out_ready=0, push 5 valid ALU ops -> first 4 accepted, in_ready=0 at level=4. Release out_ready -> 4 words appear in order at addresses 0..3, then the 5th is accepted.
- Push op=0 a=F b=F c=F and op=15 a=1 -> words 16'h0000 then 16'h000F. State goes DRAIN and then HALTED after the second pop, halted=1, in_ready=0.
- Push op=13 -> handshake completes, nothing emitted, err_reserved=1 sticky. Restart in RUN -> still 1. Halt then restart -> err_reserved=0, out_addr=0.
- ADDR_W=2: stream 5 words -> addresses 0,1,2,3,0.
- Assert rst_n=0 with level=3 and out_valid=1 -> out_valid=0 and level=0 immediately, no stray word after release.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs field-level instruction requests into 16-bit words and streams them,
// with sequential write addresses, to the instruction-memory write port.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  input  logic [3:0]               in_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_instr,
  output logic [ADDR_W-1:0]        out_addr,
  input  logic                     restart,
  output logic                     halted,
  output logic                     err_reserved,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] op;
  } req_t;

  state_e            state_q;
  logic [15:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  req_t        req;
  logic [15:0] word;
  logic        accept, rsvd, push, pop;

  assign req      = '{a: in_a, b: in_b, c: in_c, op: in_op};
  assign in_ready = (state_q == S_RUN) && (level_q < FULL);
  assign accept   = in_valid && in_ready;
  assign rsvd     = (in_op == 4'hD) || (in_op == 4'hE);
  assign push     = accept && !rsvd;
  assign out_valid = (level_q != '0) && (state_q != S_HALTED);
  assign pop      = out_valid && out_ready;

  // Noop and Halt have a single canonical encoding regardless of fields.
  always_comb begin
    word = req;
    if (in_op == 4'h0) word = 16'h0000;
    if (in_op == 4'hF) word = 16'h000F;
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        addr_q   <= addr_q + 1'b1;
      end
      if (accept && rsvd) err_q <= 1'b1;
      case (state_q)
        S_RUN:    if (accept && in_op == 4'hF) state_q <= S_DRAIN;
        S_DRAIN:  if (level_d == '0) state_q <= S_HALTED;
        S_HALTED: if (restart) begin
          state_q <= S_RUN;
          addr_q  <= '0;
          err_q   <= 1'b0;
        end
        default:  state_q <= S_RUN;
      endcase
    end
  end

  // Gate the head so a stale entry never appears on the bus.
  assign out_instr    = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign out_addr     = addr_q;
  assign halted       = (state_q == S_HALTED);
  assign err_reserved = err_q;
  assign level        = level_q;

endmodule
